// File: rtl/fir_avg_filter.sv
// N-tap moving-average filter for one signed audio channel: each sample is
// pre-scaled by 1/N and the output is the running sum of the last N scaled samples.
module fir_avg_filter #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 3
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] data_in,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     filled
);

    localparam int N = 2 ** LOG2_N;
    localparam logic [LOG2_N:0] N_CNT = (LOG2_N + 1)'(N);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   state;
    logic [LOG2_N-1:0]        wptr;
    logic [LOG2_N:0]          count;
    logic signed [DATA_W-1:0] acc_p1;
    logic signed [DATA_W-1:0] taps [N];

    logic                     vld_p0;
    logic signed [DATA_W-1:0] s_p0;
    logic signed [DATA_W-1:0] old_p0;
    logic signed [DATA_W-1:0] acc_next_p0;

    // Arithmetic shift floors toward -inf, so -1 stays -1 and 7 becomes 0.
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W-1:0] x);
        return x >>> LOG2_N;
    endfunction

    // Stage p0: scale the new sample, fetch the sample leaving the window.
    // The intermediate acc + s may wrap, but the final sum fits in DATA_W,
    // so modular arithmetic gives the exact result without saturation.
    always_comb begin
        vld_p0      = en && !reset;
        s_p0        = scale(data_in);
        old_p0      = (state == RUN) ? taps[wptr] : '0;
        acc_next_p0 = acc_p1 + s_p0 - old_p0;
    end

    // Tap storage is never reset; entries are always written before being read.
    always_ff @(posedge CLOCK_50) begin
        if (vld_p0) begin
            taps[wptr] <= s_p0;
        end
    end

    // Stage p1: accumulator and window control.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= FILL;
            count  <= '0;
            wptr   <= '0;
            acc_p1 <= '0;
            filled <= 1'b0;
        end else if (en) begin
            wptr   <= wptr + 1'b1;
            acc_p1 <= acc_next_p0;
            case (state)
                FILL: begin
                    count <= count + 1'b1;
                    if (count == N_CNT - 1'b1) begin
                        state  <= RUN;
                        filled <= 1'b1;
                    end
                end
                RUN: begin
                    count <= N_CNT;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    assign data_out = acc_p1;

endmodule

// File: tb/tb_fir_avg_filter.sv
// Bench for fir_avg_filter: fixed vector table for the directed scenarios,
// then randomized traffic against a window-sum reference model.
module tb_fir_avg_filter;

    localparam int DATA_W = 24;
    localparam int LOG2_N = 3;
    localparam int N      = 2 ** LOG2_N;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     en;
    logic signed [DATA_W-1:0] data_in;
    logic signed [DATA_W-1:0] data_out;
    logic                     filled;

    fir_avg_filter #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .en      (en),
        .data_in (data_in),
        .data_out(data_out),
        .filled  (filled)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic                     rst;
        logic                     en;
        logic signed [DATA_W-1:0] din;
        logic signed [DATA_W-1:0] exp_out;
        logic                     exp_filled;
        int                       tid;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void add(logic r, logic e, int din, int exp_out, logic exp_f, int tid);
        vec_t v;
        v.rst        = r;
        v.en         = e;
        v.din        = DATA_W'(din);
        v.exp_out    = DATA_W'(exp_out);
        v.exp_filled = exp_f;
        v.tid        = tid;
        vecs.push_back(v);
    endfunction

    // Floor division by N done with plain integer arithmetic.
    function automatic int floor_div_n(int v);
        if (v >= 0) return v / N;
        return -((-v + N - 1) / N);
    endfunction

    task automatic drive(logic r, logic e, logic signed [DATA_W-1:0] d);
        reset   = r;
        en      = e;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(string name, int idx, logic signed [DATA_W-1:0] exp_v);
        tests++;
        if (data_out !== exp_v) begin
            fails++;
            $display("FAIL %s[%0d] data_out: got %0d required %0d", name, idx, data_out, exp_v);
        end
    endtask

    task automatic check_filled(string name, int idx, logic exp_v);
        tests++;
        if (filled !== exp_v) begin
            fails++;
            $display("FAIL %s[%0d] filled: got %0b required %0b", name, idx, filled, exp_v);
        end
    endtask

    initial begin
        int hist[$];
        int sum;
        int s;
        int v;
        logic r;
        logic e;
        logic signed [DATA_W-1:0] d;

        reset   = 1'b1;
        en      = 1'b0;
        data_in = '0;

        // 1: reset, then idle
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 1);
        // 2: ramp up on 800, with an idle gap that must hold the output
        for (int i = 1; i <= 8; i++) begin
            add(0, 1, 800, 100 * i, (i == 8), 2);
            if (i == 4) for (int j = 0; j < 3; j++) add(0, 0, 555, 400, 0, 2);
        end
        for (int i = 0; i < 4; i++) add(0, 1, 800, 800, 1, 2);
        // 3: decay on zeros
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 800 - 100 * i, 1, 3);
        // 4: negative samples, then 7 which scales to 0
        add(1, 0, 0, 0, 0, 4);
        for (int i = 1; i <= 8; i++) add(0, 1, -8, -i, (i == 8), 4);
        for (int i = 1; i <= 8; i++) add(0, 1, 7, -8 + i, 1, 4);
        // 5: reset together with en discards the sample
        add(1, 0, 0, 0, 0, 5);
        for (int i = 1; i <= 5; i++) add(0, 1, 800, 100 * i, 0, 5);
        add(1, 1, 800, 0, 0, 5);
        add(0, 1, 80, 10, 0, 5);
        // 6: full-scale positive then full-scale negative, no wrap
        add(1, 0, 0, 0, 0, 6);
        for (int i = 1; i <= 16; i++)
            add(0, 1, 24'h7FFFFF, (i < 8 ? i : 8) * 1048575, (i >= 8), 6);
        for (int i = 1; i <= 16; i++)
            add(0, 1, -8388608, (i < 8 ? (8 - i) * 1048575 - i * 1048576 : -8388608), 1, 6);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].din);
            check_out($sformatf("t%0d", vecs[i].tid), i, vecs[i].exp_out);
            check_filled($sformatf("t%0d", vecs[i].tid), i, vecs[i].exp_filled);
        end

        // Randomized traffic against a window-of-last-N-samples model.
        drive(1, 0, '0);
        hist.delete();
        for (int c = 0; c < 2000; c++) begin
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       d = 24'sh7FFFFF;
                1:       d = -24'sh800000;
                default: d = DATA_W'($urandom);
            endcase
            drive(r, e, d);
            if (r) begin
                hist.delete();
            end else if (e) begin
                v = d;
                hist.push_back(floor_div_n(v));
                if (hist.size() > N) void'(hist.pop_front());
            end
            sum = 0;
            foreach (hist[k]) sum += hist[k];
            s = sum;
            check_out("rand", c, DATA_W'(s));
            check_filled("rand", c, hist.size() == N);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
